// File: rtl/fft_energy_pkg.sv
// Shared types, default parameters and helpers for the FFT band-energy stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fft_energy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam int DEF_NUM_BANDS = 7;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_ACC_W     = 40;
  localparam int DEF_LEVEL_W   = 4;
  localparam int DEF_SHIFT_W   = 6;
  localparam int DEF_RD_LAT    = 2;

  // Unsigned add clamped to 2^w-1; operands are zero-extended to 64 bits by
  // the caller, so w may be anything up to 63.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int          w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    if (sum > lim) return lim[63:0];
    return sum[63:0];
  endfunction

endpackage

// File: rtl/fft_level_quant.sv
// Quantise one band energy to a display level: shift right, clamp to all-ones.
// Latency: combinational.
// Backpressure: none.
// Ports: energy (band energy), shift (right shift amount), level (clamped result).
module fft_level_quant
  import fft_energy_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int LEVEL_W = DEF_LEVEL_W
) (
  input  logic [ACC_W-1:0]   energy,
  input  logic [SHIFT_W-1:0] shift,
  output logic [LEVEL_W-1:0] level
);

  logic [ACC_W-1:0] q;

  always_comb begin
    q = '0;
    // Shifts of ACC_W or more discard every bit.
    if (int'(shift) < ACC_W) q = energy >> shift;
    level = ((q >> LEVEL_W) != '0) ? '1 : q[LEVEL_W-1:0];
  end

endmodule

// File: rtl/fft_band_energy.sv
// Stream one FFT frame from the spectrum BRAM, sum squared magnitudes per band, commit energies and levels atomically.
// Latency: start to done is E + RD_LAT + 2 cycles (E = last band end address).
// Backpressure: none; start is ignored while busy, BRAM is read one address per cycle without stalls.
// Ports: clock/reset_n; start, band_end, shift, hold (frame config, latched on start except hold);
//        bram_addr/bram_data (BRAM read port); busy, done, energy, level (status and committed results).
// Build option: define FFT_BAND_PEAK_HOLD_EN for peak-hold level decay of one step per frame.
module fft_band_energy
  import fft_energy_pkg::*;
#(
  parameter int NUM_BANDS = DEF_NUM_BANDS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int LEVEL_W   = DEF_LEVEL_W,
  parameter int SHIFT_W   = DEF_SHIFT_W,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [NUM_BANDS*ADDR_W-1:0]    band_end,
  input  logic [NUM_BANDS*SHIFT_W-1:0]   shift,
  input  logic                           hold,
  output logic [ADDR_W-1:0]              bram_addr,
  input  logic [DATA_W-1:0]              bram_data,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_BANDS*ACC_W-1:0]     energy,
  output logic [NUM_BANDS*LEVEL_W-1:0]   level
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  state_t state, state_nxt;

  logic [NUM_BANDS-1:0][ADDR_W-1:0]  end_q;
  logic [NUM_BANDS-1:0][SHIFT_W-1:0] shift_q;
  logic [NUM_BANDS-1:0][ACC_W-1:0]   acc_q;
  logic [NUM_BANDS-1:0][ACC_W-1:0]   energy_q;
  logic [NUM_BANDS-1:0][LEVEL_W-1:0] level_q;
  logic [NUM_BANDS-1:0][LEVEL_W-1:0] quant;
  logic [NUM_BANDS-1:0][LEVEL_W-1:0] commit_level;

  // Band membership travels with each read as a mask so that overlapping or
  // empty ranges follow the interval rule exactly.
  logic [RD_LAT-1:0]                 vld_pipe;
  logic [RD_LAT-1:0][NUM_BANDS-1:0]  tag_pipe;
  logic [NUM_BANDS-1:0]              addr_tag;

  logic [CNT_W-1:0]                  drain_cnt;
  logic [ADDR_W-1:0]                 last_addr;
  logic [2*DATA_W-1:0]               data_ext;
  logic [2*DATA_W-1:0]               prod;

  assign last_addr = end_q[NUM_BANDS-1] - ADDR_W'(1);
  assign data_ext  = {{DATA_W{1'b0}}, bram_data};
  assign prod      = data_ext * data_ext;
  assign busy      = (state != IDLE);
  assign energy    = energy_q;
  assign level     = level_q;

  always_comb begin
    addr_tag    = '0;
    addr_tag[0] = (bram_addr < end_q[0]);
    for (int k = 1; k < NUM_BANDS; k++) begin
      addr_tag[k] = (bram_addr >= end_q[k-1]) && (bram_addr < end_q[k]);
    end
  end

  for (genvar k = 0; k < NUM_BANDS; k++) begin : g_quant
    fft_level_quant #(
      .ACC_W   (ACC_W),
      .SHIFT_W (SHIFT_W),
      .LEVEL_W (LEVEL_W)
    ) u_quant (
      .energy (acc_q[k]),
      .shift  (shift_q[k]),
      .level  (quant[k])
    );
  end

`ifdef FFT_BAND_PEAK_HOLD_EN
  logic [LEVEL_W-1:0] decayed;

  always_comb begin
    commit_level = quant;
    decayed      = '0;
    for (int k = 0; k < NUM_BANDS; k++) begin
      decayed = (level_q[k] == '0) ? '0 : level_q[k] - LEVEL_W'(1);
      if (decayed > quant[k]) commit_level[k] = decayed;
    end
  end
`else
  always_comb begin
    commit_level = quant;
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // The latched copy is not yet available, so test the live end address.
        if (start) begin
          state_nxt = (band_end[NUM_BANDS*ADDR_W-1 -: ADDR_W] == '0) ? DRAIN : RUN;
        end
      end
      RUN:    if (bram_addr == last_addr) state_nxt = DRAIN;
      DRAIN:  if (drain_cnt == CNT_W'(RD_LAT - 1)) state_nxt = COMMIT;
      COMMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      end_q     <= '0;
      shift_q   <= '0;
      acc_q     <= '0;
      energy_q  <= '0;
      level_q   <= '0;
      vld_pipe  <= '0;
      tag_pipe  <= '0;
      drain_cnt <= '0;
      bram_addr <= '0;
      done      <= 1'b0;
    end else begin
      done        <= 1'b0;
      vld_pipe[0] <= (state == RUN);
      tag_pipe[0] <= addr_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end

      if (vld_pipe[RD_LAT-1]) begin
        for (int k = 0; k < NUM_BANDS; k++) begin
          if (tag_pipe[RD_LAT-1][k]) begin
            acc_q[k] <= ACC_W'(sat_add(64'(acc_q[k]), 64'(prod), ACC_W));
          end
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            end_q     <= band_end;
            shift_q   <= shift;
            bram_addr <= '0;
            acc_q     <= '0;
            drain_cnt <= '0;
          end
        end
        RUN: begin
          if (bram_addr != last_addr) bram_addr <= bram_addr + ADDR_W'(1);
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + CNT_W'(1);
        end
        COMMIT: begin
          energy_q <= acc_q;
          if (!hold) level_q <= commit_level;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_band_energy.sv
// Bench for fft_band_energy: BRAM model, interval-rule reference model and done-triggered scoreboard.
module tb_fft_band_energy;

  localparam int NUM_BANDS = 7;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 10;
  localparam int ACC_W     = 32;
  localparam int LEVEL_W   = 4;
  localparam int SHIFT_W   = 6;
  localparam int RD_LAT    = 2;
  localparam int EW        = NUM_BANDS * ADDR_W;
  localparam int SW        = NUM_BANDS * SHIFT_W;
  localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 64'd1;
  localparam int LVL_MAX   = (1 << LEVEL_W) - 1;

  logic                         clock = 1'b0;
  logic                         reset_n;
  logic                         start;
  logic [EW-1:0]                band_end;
  logic [SW-1:0]                shift;
  logic                         hold;
  logic [ADDR_W-1:0]            bram_addr;
  logic [DATA_W-1:0]            bram_data;
  logic                         busy;
  logic                         done;
  logic [NUM_BANDS*ACC_W-1:0]   energy;
  logic [NUM_BANDS*LEVEL_W-1:0] level;

  fft_band_energy #(
    .NUM_BANDS (NUM_BANDS),
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .ACC_W     (ACC_W),
    .LEVEL_W   (LEVEL_W),
    .SHIFT_W   (SHIFT_W),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .band_end  (band_end),
    .shift     (shift),
    .hold      (hold),
    .bram_addr (bram_addr),
    .bram_data (bram_data),
    .busy      (busy),
    .done      (done),
    .energy    (energy),
    .level     (level)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Spectrum BRAM with RD_LAT cycles of read latency.
  logic [DATA_W-1:0] mem [1024];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clock) begin
    rd_pipe[0] <= mem[bram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_data = rd_pipe[RD_LAT-1];

  typedef struct {
    longint unsigned energy [NUM_BANDS];
    int              level  [NUM_BANDS];
    int              start_cyc;
    int              lat;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  int   model_level [NUM_BANDS];
  int   cfg_end     [NUM_BANDS];
  int   cfg_shift   [NUM_BANDS];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  function automatic logic [EW-1:0] pack_end();
    logic [EW-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_BANDS; k++) v[k*ADDR_W +: ADDR_W] = ADDR_W'(cfg_end[k]);
    return v;
  endfunction

  function automatic logic [SW-1:0] pack_shift();
    logic [SW-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_BANDS; k++) v[k*SHIFT_W +: SHIFT_W] = SHIFT_W'(cfg_shift[k]);
    return v;
  endfunction

  // Reference: band k sums squares over addresses in [lo_k, hi_k) that the
  // frame actually reads (0..E-1), clamps, then shifts and clamps to a level.
  task automatic push_expect(input logic hold_v);
    exp_t            e;
    longint unsigned sum;
    longint unsigned q;
    int              lo, hi, e_end, nl;
    e_end = cfg_end[NUM_BANDS-1];
    for (int k = 0; k < NUM_BANDS; k++) begin
      lo  = (k == 0) ? 0 : cfg_end[k-1];
      hi  = cfg_end[k];
      sum = 0;
      for (int a = lo; a < hi && a < e_end; a++) sum += 64'(mem[a]) * 64'(mem[a]);
      if (sum > ACC_MAX) sum = ACC_MAX;
      q  = (cfg_shift[k] >= ACC_W) ? 64'd0 : (sum >> cfg_shift[k]);
      nl = (q > 64'(LVL_MAX)) ? LVL_MAX : int'(q);
`ifdef FFT_BAND_PEAK_HOLD_EN
      if (model_level[k] - 1 > nl) nl = model_level[k] - 1;
`endif
      if (!hold_v) model_level[k] = nl;
      e.energy[k] = sum;
      e.level[k]  = model_level[k];
    end
    e.start_cyc = cyc;
    e.lat       = e_end + RD_LAT + 2;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  exp_t me;
  always @(negedge clock) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d (no frame pending)", cyc);
      end else begin
        me = exp_q.pop_front();
        for (int k = 0; k < NUM_BANDS; k++) begin
          chk($sformatf("energy[%0d]", k), 64'(energy[k*ACC_W +: ACC_W]), me.energy[k]);
          chk($sformatf("level[%0d]", k), 64'(level[k*LEVEL_W +: LEVEL_W]), 64'(me.level[k]));
        end
        chk("latency", 64'(cyc - me.start_cyc), 64'(me.lat));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
      done_seen++;
    end
  end

  task automatic run_frame(input logic hold_v, input int extra_at);
    int n;
    int seen0;
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    band_end = pack_end();
    shift    = pack_shift();
    hold     = hold_v;
    start    = 1'b1;
    push_expect(hold_v);
    seen0 = done_seen;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      start = (n == extra_at);
      if (n == 1) begin
        band_end = EW'({$urandom, $urandom, $urandom});
        shift    = SW'({$urandom, $urandom});
      end
    end while (done_seen == seen0 && n < 3000);
    start = 1'b0;
    if (done_seen == seen0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout waited=%0d cycles without done", n);
      exp_q.delete();
    end
  endtask

  task automatic randomize_frame();
    int maxv;
    maxv = ($urandom_range(0, 1) == 1) ? 65535 : 4095;
    for (int a = 0; a < 1024; a++) mem[a] = DATA_W'($urandom_range(0, maxv));
    for (int k = 0; k < NUM_BANDS; k++) begin
      cfg_end[k]   = $urandom_range(0, 120);
      cfg_shift[k] = $urandom_range(0, 40);
    end
    cfg_end[NUM_BANDS-1] = $urandom_range(10, 120);
  endtask

  initial begin
    int n;
    reset_n  = 1'b0;
    start    = 1'b0;
    band_end = '0;
    shift    = '0;
    hold     = 1'b0;
    for (int a = 0; a < 1024; a++) mem[a] = '0;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
    for (int k = 0; k < NUM_BANDS; k++) model_level[k] = 0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_addr", 64'(bram_addr), 0);
    chk("rst_level", 64'(level), 0);
    for (int k = 0; k < NUM_BANDS; k++) chk("rst_energy", 64'(energy[k*ACC_W +: ACC_W]), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Ramp data, two addresses per band.
    for (int a = 0; a < 1024; a++) mem[a] = DATA_W'(a + 1);
    for (int k = 0; k < NUM_BANDS; k++) begin
      cfg_end[k]   = 2 * (k + 1);
      cfg_shift[k] = 0;
    end
    run_frame(1'b0, -1);
    chk("ramp_energy0", 64'(energy[0 +: ACC_W]), 5);
    chk("ramp_energy1", 64'(energy[ACC_W +: ACC_W]), 25);
    chk("ramp_level0", 64'(level[0 +: LEVEL_W]), 5);
    chk("ramp_level1", 64'(level[LEVEL_W +: LEVEL_W]), 15);

    // Empty band between two populated ones.
    for (int a = 0; a < 1024; a++) mem[a] = 16'd3;
    cfg_end = '{4, 4, 8, 12, 16, 20, 24};
    cfg_shift = '{0, 0, 2, 3, 4, 5, 6};
    run_frame(1'b0, -1);
    chk("empty_energy1", 64'(energy[ACC_W +: ACC_W]), 0);
    chk("empty_energy2", 64'(energy[2*ACC_W +: ACC_W]), 36);

    // Saturation over a long frame; shift >= ACC_W gives level 0.
    for (int a = 0; a < 1024; a++) mem[a] = 16'hFFFF;
    cfg_end = '{600, 1023, 1023, 1023, 1023, 1023, 1023};
    cfg_shift = '{28, 32, 0, 40, 63, 31, 4};
    run_frame(1'b0, -1);
    chk("sat_energy0", 64'(energy[0 +: ACC_W]), ACC_MAX);
    chk("sat_level0", 64'(level[0 +: LEVEL_W]), 15);

    // Zero-length frame.
    for (int k = 0; k < NUM_BANDS; k++) cfg_end[k] = 0;
    run_frame(1'b0, -1);

    // Frame A then frame B under hold.
    randomize_frame();
    run_frame(1'b0, -1);
    randomize_frame();
    run_frame(1'b1, -1);

    // Level 9 followed by two frames computing 2.
    for (int k = 0; k < NUM_BANDS; k++) begin
      cfg_end[k]   = 1;
      cfg_shift[k] = 0;
    end
    mem[0] = 16'd3;
    run_frame(1'b0, -1);
    mem[0] = 16'd1;
    mem[1] = 16'd1;
    for (int k = 0; k < NUM_BANDS; k++) cfg_end[k] = 2;
    run_frame(1'b0, -1);
    run_frame(1'b0, -1);

    // Random frames; one carries a start pulse while busy.
    for (int f = 0; f < 12; f++) begin
      randomize_frame();
      run_frame(1'(($urandom_range(0, 3) == 0)), (f == 4) ? 5 : -1);
      if (f == 4) repeat (20) @(negedge clock);
    end

    // Reset pulled mid-frame at address 5.
    randomize_frame();
    for (int k = 0; k < NUM_BANDS; k++) cfg_end[k] = 10 * (k + 1);
    band_end = pack_end();
    shift    = pack_shift();
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (bram_addr != ADDR_W'(5) && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("reach_addr5", 64'(bram_addr), 5);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_done", 64'(done), 0);
    chk("mid_rst_addr", 64'(bram_addr), 0);
    chk("mid_rst_level", 64'(level), 0);
    for (int k = 0; k < NUM_BANDS; k++) chk("mid_rst_energy", 64'(energy[k*ACC_W +: ACC_W]), 0);
    for (int k = 0; k < NUM_BANDS; k++) model_level[k] = 0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    run_frame(1'b0, -1);

    repeat (20) @(negedge clock);
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
